wb_protocol_checker: RTL and testbench
======================================

# wb_protocol_checker

Synthesizable, parametrised Wishbone B3 classic-cycle bus checker that sits passively on the host-side Wishbone port of the SDRAM controller, alongside the bench assertions. Turns the simulation-only reset/initiation/termination rule checks into hardware: a per-transfer state machine, a wait-state watchdog, signal-stability checks, sticky error flags and saturating event counters readable by the bench or a debug register block. It drives nothing on the bus.

## Interface
- DW, 32: data width; multiple of 8.
- AW, 26: address width.
- TIMEOUT, 64: consecutive wait cycles before a timeout error; minimum 2.
- CNT_W, 16: width of the transfer and error counters.

- wb_clk_i  in  1  Wishbone clock. Sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  observed master CYC.
- wb_stb_i  in  1  observed master STB.
- wb_we_i  in  1  observed master WE.
- wb_sel_i  in  DW/8  observed master SEL.
- wb_addr_i  in  AW  observed master address.
- wb_dat_i  in  DW  observed master write data.
- wb_ack_o  in  1  observed slave ACK (slave-side name kept).
- wb_err_o  in  1  observed slave ERR.
- clr_i  in  1  synchronous clear of flags, first-code and counters.
- err_flags  out  8  sticky violation flags, bit map below.
- err_first  out  3  index of the first violation since reset or clear.
- err_first_vld  out  1  err_first is valid.
- err_cnt  out  CNT_W  violation cycles, saturating.
- xfer_cnt  out  CNT_W  completed transfers (ACK or ERR), saturating.
- irq  out  1  OR of err_flags.

## Operation
- pend = cyc & stb & !ack & !err; term = cyc & stb & (ack | err).
- FSM states: S_RST, S_IDLE, S_CYC, S_PEND.
  - Reset forces S_RST. S_RST -> S_IDLE after one clock with reset low.
  - S_IDLE: cyc -> S_CYC, or S_PEND if pend.
  - S_CYC: !cyc -> S_IDLE; pend -> S_PEND.
  - S_PEND: term -> S_CYC (or S_IDLE if !cyc); stb or cyc dropped -> S_CYC/S_IDLE (abort, not an error).
- Violation bits:
  - 0 RST_CYC: cyc or stb high in S_RST.
  - 1 STB_NO_CYC: stb high with cyc low.
  - 2 RESP_NO_REQ: ack or err high without cyc & stb.
  - 3 TIMEOUT: wait counter reaches TIMEOUT.
  - 4 ADDR_CHG: address changed while in S_PEND.
  - 5 CTRL_CHG: we or sel changed while in S_PEND.
  - 6 WDATA_CHG: dat changed while in S_PEND with we = 1.
  - 7 MULTI_TERM: ack and err high in the same cycle.
- Wait counter:
  - Increments each pend cycle; clears on any non-pend cycle.
  - Saturates at TIMEOUT, so bit 3 is flagged once per transfer.
- Stability checks compare against values registered on the previous pend cycle; evaluated only when the previous cycle and the current cycle are both cyc & stb.
- err_cnt increments by 1 per cycle with any new violation, whatever the number of bits. xfer_cnt increments per term. Both saturate at all-ones.
- err_first takes the lowest set bit of the first violating cycle; it is held until clear.
- clr_i clears all flags and counters. A violation or term in the same cycle wins: that flag is set and its counter reads 1.

## Timing
- All outputs are registered. Reset value is 0 for every output.
- A violation sampled at edge N appears on err_flags/irq/err_cnt after edge N, i.e. 1-cycle latency.
- TIMEOUT is flagged after the edge ending the TIMEOUT-th consecutive pend cycle.
- Reset asserted mid-transfer: FSM, counter and outputs clear immediately; the in-flight transfer is not counted.
- Zero-wait transfer (ack in the first stb cycle): counted; no stability check applies.

## Configuration
- WB_CHK_STABLE_EN defined: bits 4-6 implemented with their holding registers.
- Not defined: bits 4-6 tied to 0, no holding registers, and they never contribute to err_cnt or err_first.

## Test plan
- Reset release with cyc = 1 in the first cycle -> err_flags = 0x01, err_first = 0, err_cnt = 1, irq = 1 one cycle later.
- 10 single writes, each acked after 3 waits, TIMEOUT = 64 -> xfer_cnt = 10, err_flags = 0x00.
- stb held, no ack for 70 cycles, TIMEOUT = 64 -> bit 3 set exactly after the 64th wait edge; err_cnt = 1.
- Write pending with addr 0x100 -> 0x104 on the 2nd wait cycle (WB_CHK_STABLE_EN defined) -> err_flags = 0x10. Same stimulus with the macro undefined -> err_flags = 0x00.
- ack and err together with no stb, in one cycle -> err_flags = 0x84, err_first = 2, err_cnt = 1.
- clr_i in the same cycle as a stb-without-cyc violation -> err_flags = 0x02, err_cnt = 1, xfer_cnt = 0.

Source files
------------

// File: rtl/wb_protocol_checker.sv
// Passive Wishbone B3 classic-cycle checker: transfer FSM, wait watchdog, sticky flags, counters.
// Define WB_CHK_STABLE_EN to add address/control/write-data stability checks (flag bits 4-6).

module wb_protocol_checker #(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [DW/8-1:0]  wb_sel_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic             wb_ack_o,
  input  logic             wb_err_o,
  input  logic             clr_i,
  output logic [7:0]       err_flags,
  output logic [2:0]       err_first,
  output logic             err_first_vld,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             irq
);

  localparam int SW  = DW / 8;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]   WAIT_ONE  = WCW'(1);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]   WAIT_SAT  = WCW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_IDLE = 2'd1,
    S_CYC  = 2'd2,
    S_PEND = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WCW-1:0]   wait_cnt_r;
  logic             req_s;
  logic             pend_s;
  logic             term_s;
  logic [2:0]       stab_viol_s;
  logic [7:0]       viol_s;
  logic [7:0]       flags_nxt_s;
  logic [2:0]       first_nxt_s;
  logic             first_vld_nxt_s;
  logic [CNT_W-1:0] err_base_s;
  logic [CNT_W-1:0] xfer_base_s;
  logic [CNT_W-1:0] err_cnt_nxt_s;
  logic [CNT_W-1:0] xfer_cnt_nxt_s;

  // Priority encoder: index of the lowest set violation bit.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Bus phase decode.
  always_comb begin
    req_s  = wb_cyc_i & wb_stb_i;
    pend_s = req_s & ~wb_ack_o & ~wb_err_o;
    term_s = req_s & (wb_ack_o | wb_err_o);
  end

  // Transfer FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RST: begin
        state_nxt_s = S_IDLE;
      end
      S_IDLE: begin
        if (pend_s) begin
          state_nxt_s = S_PEND;
        end else if (wb_cyc_i) begin
          state_nxt_s = S_CYC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CYC: begin
        if (!wb_cyc_i) begin
          state_nxt_s = S_IDLE;
        end else if (pend_s) begin
          state_nxt_s = S_PEND;
        end else begin
          state_nxt_s = S_CYC;
        end
      end
      S_PEND: begin
        // Termination and master abort both leave the wait phase the same way.
        if (!wb_cyc_i) begin
          state_nxt_s = S_IDLE;
        end else if (pend_s) begin
          state_nxt_s = S_PEND;
        end else begin
          state_nxt_s = S_CYC;
        end
      end
      default: begin
        state_nxt_s = S_RST;
      end
    endcase
  end

  // Transfer FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= S_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Consecutive wait-cycle counter; saturates so the timeout fires once per transfer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (!pend_s) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (wait_cnt_r != WAIT_SAT) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

`ifdef WB_CHK_STABLE_EN
  logic [AW-1:0] addr_hold_r;
  logic [SW-1:0] sel_hold_r;
  logic [DW-1:0] dat_hold_r;
  logic          we_hold_r;
  logic          chk_s;

  // Snapshot of the request on every wait cycle, reference for the next cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr_hold_r <= {AW{1'b0}};
      sel_hold_r  <= {SW{1'b0}};
      dat_hold_r  <= {DW{1'b0}};
      we_hold_r   <= 1'b0;
    end else if (pend_s) begin
      addr_hold_r <= wb_addr_i;
      sel_hold_r  <= wb_sel_i;
      dat_hold_r  <= wb_dat_i;
      we_hold_r   <= wb_we_i;
    end else begin
      addr_hold_r <= addr_hold_r;
      sel_hold_r  <= sel_hold_r;
      dat_hold_r  <= dat_hold_r;
      we_hold_r   <= we_hold_r;
    end
  end

  // S_PEND implies the previous cycle was a wait cycle, so only cyc & stb now is needed.
  always_comb begin
    chk_s          = (state_r == S_PEND) & req_s;
    stab_viol_s    = 3'b000;
    stab_viol_s[0] = chk_s & (wb_addr_i != addr_hold_r);
    stab_viol_s[1] = chk_s & ((wb_we_i != we_hold_r) | (wb_sel_i != sel_hold_r));
    stab_viol_s[2] = chk_s & wb_we_i & (wb_dat_i != dat_hold_r);
  end
`else
  logic unused_stab_s;

  assign stab_viol_s   = 3'b000;
  assign unused_stab_s = ^{wb_we_i, wb_sel_i, wb_addr_i, wb_dat_i};
`endif

  // Per-cycle violation vector.
  always_comb begin
    viol_s      = 8'h00;
    viol_s[0]   = (state_r == S_RST) & (wb_cyc_i | wb_stb_i);
    viol_s[1]   = wb_stb_i & ~wb_cyc_i;
    viol_s[2]   = (wb_ack_o | wb_err_o) & ~req_s;
    viol_s[3]   = pend_s & (wait_cnt_r == WAIT_LAST);
    viol_s[6:4] = stab_viol_s;
    viol_s[7]   = wb_ack_o & wb_err_o;
  end

  // Next values for flags, first-code and counters; a same-cycle event beats clr_i.
  always_comb begin
    if (clr_i) begin
      flags_nxt_s = viol_s;
      err_base_s  = {CNT_W{1'b0}};
      xfer_base_s = {CNT_W{1'b0}};
    end else begin
      flags_nxt_s = err_flags | viol_s;
      err_base_s  = err_cnt;
      xfer_base_s = xfer_cnt;
    end

    if ((|viol_s) && (err_base_s != CNT_MAX)) begin
      err_cnt_nxt_s = err_base_s + CNT_ONE;
    end else begin
      err_cnt_nxt_s = err_base_s;
    end

    if (term_s && (xfer_base_s != CNT_MAX)) begin
      xfer_cnt_nxt_s = xfer_base_s + CNT_ONE;
    end else begin
      xfer_cnt_nxt_s = xfer_base_s;
    end

    if (!clr_i && err_first_vld) begin
      first_nxt_s     = err_first;
      first_vld_nxt_s = 1'b1;
    end else if (|viol_s) begin
      first_nxt_s     = lowest_set(viol_s);
      first_vld_nxt_s = 1'b1;
    end else begin
      first_nxt_s     = 3'd0;
      first_vld_nxt_s = 1'b0;
    end
  end

  // Registered status outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_flags     <= 8'h00;
      err_first     <= 3'd0;
      err_first_vld <= 1'b0;
      err_cnt       <= {CNT_W{1'b0}};
      xfer_cnt      <= {CNT_W{1'b0}};
      irq           <= 1'b0;
    end else begin
      err_flags     <= flags_nxt_s;
      err_first     <= first_nxt_s;
      err_first_vld <= first_vld_nxt_s;
      err_cnt       <= err_cnt_nxt_s;
      xfer_cnt      <= xfer_cnt_nxt_s;
      irq           <= |flags_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_protocol_checker.sv
// Directed self-checking bench for wb_protocol_checker (default parameters).
// Expectations for flag bits 4-6 follow whether WB_CHK_STABLE_EN is defined for the build.

module tb_wb_protocol_checker;

  localparam int DW      = 32;
  localparam int AW      = 26;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;
`ifdef WB_CHK_STABLE_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cyc, stb, we, ack, err, clr;
  logic [DW/8-1:0]  sel;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    dat;
  logic [7:0]       err_flags;
  logic [2:0]       err_first;
  logic             err_first_vld;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] xfer_cnt;
  logic             irq;

  int checks = 0;
  int errors = 0;

  wb_protocol_checker #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(dat), .wb_ack_o(ack), .wb_err_o(err),
    .clr_i(clr), .err_flags(err_flags), .err_first(err_first), .err_first_vld(err_first_vld),
    .err_cnt(err_cnt), .xfer_cnt(xfer_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0; err = 1'b0;
    sel = 4'h0; addr = 26'h0; dat = 32'h0;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    bus_idle();
    tick(); tick();
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h expected %h", err_flags, 8'h00); end
    checks++; if ({err_first_vld, err_first, irq} !== 5'b0) begin errors++; $display("FAIL reset_first_irq: got %b expected %b", {err_first_vld, err_first, irq}, 5'b0); end
    checks++; if ({err_cnt, xfer_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnts: got %h expected %h", {err_cnt, xfer_cnt}, 32'h0); end
    rst = 1'b0;
    tick();
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL reset_idle_release: got %h expected %h", err_flags, 8'h00); end
    tick();
  endtask

  task automatic test_rst_cyc();
    rst = 1'b1;
    tick();
    cyc = 1'b1;
    rst = 1'b0;
    tick();
    checks++; if (err_flags !== 8'h01) begin errors++; $display("FAIL rst_cyc_flags: got %h expected %h", err_flags, 8'h01); end
    checks++; if (err_first !== 3'd0 || err_first_vld !== 1'b1) begin errors++; $display("FAIL rst_cyc_first: got %0d/%b expected 0/1", err_first, err_first_vld); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL rst_cyc_cnt: got %0d expected %0d", err_cnt, 1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_cyc_irq: got %b expected %b", irq, 1'b1); end
    tick();
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL rst_cyc_once: got %0d expected %0d", err_cnt, 1); end
    cyc = 1'b0;
    tick();
    clear();
    checks++; if ({err_flags, err_first_vld, irq} !== 10'h0 || err_cnt !== 16'd0) begin errors++; $display("FAIL clear_all: got flags %h cnt %0d expected 00 0", err_flags, err_cnt); end
  endtask

  task automatic test_writes();
    for (int i = 0; i < 10; i++) begin
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
      addr = 26'(32'h200 + i * 4); dat = 32'(i);
      tick(); tick(); tick();
      ack = 1'b1;
      tick();
      bus_idle();
      tick();
      if (i == 0) begin
        checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL writes_first: got %0d expected %0d", xfer_cnt, 1); end
      end
    end
    checks++; if (xfer_cnt !== 16'd10) begin errors++; $display("FAIL writes_xfer: got %0d expected %0d", xfer_cnt, 10); end
    checks++; if (err_flags !== 8'h00 || err_cnt !== 16'd0) begin errors++; $display("FAIL writes_clean: got %h/%0d expected 00/0", err_flags, err_cnt); end
  endtask

  task automatic test_timeout();
    clear();
    cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    stb = 1'b0;
    tick();
    stb = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL timeout_early: got %h expected %h", err_flags, 8'h00); end
    tick();
    checks++; if (err_flags !== 8'h08) begin errors++; $display("FAIL timeout_flag: got %h expected %h", err_flags, 8'h08); end
    checks++; if (err_first !== 3'd3 || irq !== 1'b1) begin errors++; $display("FAIL timeout_first: got %0d/%b expected 3/1", err_first, irq); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL timeout_cnt: got %0d expected %0d", err_cnt, 1); end
    bus_idle();
    tick();
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL timeout_noxfer: got %0d expected %0d", xfer_cnt, 0); end
  endtask

  task automatic test_stability();
    logic [7:0] exp_raw;
    logic [7:0] exp;
    for (int k = 0; k < 5; k++) begin
      clear();
      cyc = 1'b1; stb = 1'b1; sel = 4'hF; addr = 26'h100; dat = 32'hA5A5_A5A5;
      we = (k == 1 || k == 3 || k == 4) ? 1'b0 : 1'b1;
      tick();
      case (k)
        0: begin addr = 26'h104; exp_raw = 8'h10; end
        1: begin sel = 4'h3; exp_raw = 8'h20; end
        2: begin dat = 32'h5A5A_5A5A; exp_raw = 8'h40; end
        3: begin dat = 32'h5A5A_5A5A; exp_raw = 8'h00; end
        default: begin we = 1'b1; exp_raw = 8'h20; end
      endcase
      tick(); tick();
      ack = 1'b1;
      tick();
      bus_idle();
      tick();
      exp = STAB ? exp_raw : 8'h00;
      checks++; if (err_flags !== exp) begin errors++; $display("FAIL stab_flags[%0d]: got %h expected %h", k, err_flags, exp); end
      checks++; if (err_cnt !== ((exp != 8'h00) ? 16'd1 : 16'd0)) begin errors++; $display("FAIL stab_cnt[%0d]: got %0d expected %0d", k, err_cnt, (exp != 8'h00)); end
      checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL stab_xfer[%0d]: got %0d expected %0d", k, xfer_cnt, 1); end
    end
  endtask

  task automatic test_multi_term();
    clear();
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    checks++; if (err_flags !== 8'h84) begin errors++; $display("FAIL multi_flags: got %h expected %h", err_flags, 8'h84); end
    checks++; if (err_first !== 3'd2 || err_first_vld !== 1'b1) begin errors++; $display("FAIL multi_first: got %0d/%b expected 2/1", err_first, err_first_vld); end
    checks++; if (err_cnt !== 16'd1 || irq !== 1'b1) begin errors++; $display("FAIL multi_cnt: got %0d/%b expected 1/1", err_cnt, irq); end
    stb = 1'b1;
    tick();
    stb = 1'b0;
    checks++; if (err_flags !== 8'h86 || err_first !== 3'd2 || err_cnt !== 16'd2) begin errors++; $display("FAIL multi_hold: got %h/%0d/%0d expected 86/2/2", err_flags, err_first, err_cnt); end
    tick();
  endtask

  task automatic test_clr_same();
    cyc = 1'b1; stb = 1'b1; ack = 1'b1;
    tick();
    bus_idle();
    checks++; if (xfer_cnt !== 16'd1 || err_flags !== 8'h86) begin errors++; $display("FAIL zero_wait: got %0d/%h expected 1/86", xfer_cnt, err_flags); end
    clr = 1'b1; stb = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_flags !== 8'h02) begin errors++; $display("FAIL clr_same_flags: got %h expected %h", err_flags, 8'h02); end
    checks++; if (err_cnt !== 16'd1 || xfer_cnt !== 16'd0) begin errors++; $display("FAIL clr_same_cnts: got %0d/%0d expected 1/0", err_cnt, xfer_cnt); end
    checks++; if (err_first !== 3'd1 || err_first_vld !== 1'b1) begin errors++; $display("FAIL clr_same_first: got %0d/%b expected 1/1", err_first, err_first_vld); end
    tick();
    stb = 1'b0;
    checks++; if (err_cnt !== 16'd2 || err_first !== 3'd1) begin errors++; $display("FAIL stb_no_cyc_repeat: got %0d/%0d expected 2/1", err_cnt, err_first); end
    tick();
  endtask

  task automatic test_back_to_back();
    clear();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; ack = 1'b1; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr = 26'(i * 4);
      dat = 32'(i);
      tick();
    end
    bus_idle();
    tick();
    checks++; if (xfer_cnt !== 16'd4) begin errors++; $display("FAIL b2b_xfer: got %0d expected %0d", xfer_cnt, 4); end
    checks++; if (err_flags !== 8'h00 || err_cnt !== 16'd0) begin errors++; $display("FAIL b2b_clean: got %h/%0d expected 00/0", err_flags, err_cnt); end
    clr = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b1;
    tick();
    clr = 1'b0;
    bus_idle();
    checks++; if (xfer_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL clr_term: got %0d/%0d expected 1/0", xfer_cnt, err_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    stb = 1'b1;
    tick();
    stb = 1'b0;
    cyc = 1'b1; stb = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (err_flags !== 8'h00 || irq !== 1'b0 || err_first_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %h/%b/%b expected 00/0/0", err_flags, irq, err_first_vld); end
    checks++; if (xfer_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnts: got %0d/%0d expected 0/0", xfer_cnt, err_cnt); end
    bus_idle();
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (xfer_cnt !== 16'd0 || err_flags !== 8'h00) begin errors++; $display("FAIL rst_mid_after: got %0d/%h expected 0/00", xfer_cnt, err_flags); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rst_cyc();
    test_writes();
    test_timeout();
    test_stability();
    test_multi_term();
    test_clr_same();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
